gate_truth_checker: RTL and testbench

Sequential truth-table checker for the two-input gate modules (the NAND-built NOT/AND family and their siblings). It drives the gate inputs `p` and `q` through all four combinations in the exercise order (1,1), (1,0), (0,1), (0,0). After a programmable settle time it samples the gate's `result`, compares it against the expected function for a selected operator, and reports per-vector failures and a pass flag. It sits beside a gate instance in a self-checking top, replacing hand-written `$monitor` inspection.

---
 rtl/gate_truth_checker.sv | 197 +++++++++++++++++++
 tb/tb_gate_truth_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Purpose: sweeps a two-input gate through (1,1),(1,0),(0,1),(0,0) and checks its result against a selected operator.
// Latency: 4*(SETTLE+2) cycles from start accept to the done pulse; 1 cycle for an invalid op.
// Backpressure: none; start is honoured only in IDLE and is dropped (not queued) while a sweep runs.
module gate_truth_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       result,
    output logic       p,
    output logic       q,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic       bad_op
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam bit         NO_WAIT    = (SETTLE == 0);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] op_q;
    logic [1:0] idx;
    logic [3:0] wait_cnt;

    logic       op_valid;
    logic       accept_ok;
    logic       accept_bad;
    logic       drive_en;
    logic       wait_en;
    logic       sample_en;
    logic       exp_bit;
    logic       mismatch;
    logic [2:0] err_nxt;

    // Reference value of the selected operator for the currently driven inputs.
    function automatic logic expected_fn(input logic [2:0] f, input logic a, input logic b);
        logic r;
        case (f)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // 110 and 111 are the only undefined operator codes.
    assign op_valid = ~(op[2] & op[1]);

    assign exp_bit  = expected_fn(op_q, p, q);
    assign mismatch = (result != exp_bit);
    assign err_nxt  = err_count + {2'b00, mismatch};

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // State register; reset aborts any sweep in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus one-hot strobes for the datapath registers.
    always_comb begin
        state_nxt  = state;
        accept_ok  = 1'b0;
        accept_bad = 1'b0;
        drive_en   = 1'b0;
        wait_en    = 1'b0;
        sample_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op_valid) begin
                        accept_ok = 1'b1;
                        state_nxt = S_DRIVE;
                    end else begin
                        // Invalid operator: report immediately, inputs untouched.
                        accept_bad = 1'b1;
                        state_nxt  = S_DONE;
                    end
                end
            end
            S_DRIVE: begin
                drive_en  = 1'b1;
                state_nxt = NO_WAIT ? S_SAMPLE : S_WAIT;
            end
            S_WAIT: begin
                wait_en = 1'b1;
                // Counter was loaded with SETTLE; the cycle it reads 1 is the last wait cycle.
                if (wait_cnt <= 4'd1) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                sample_en = 1'b1;
                state_nxt = (idx == 2'd0) ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Gate inputs follow the vector index only in DRIVE; they hold their value otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= 1'b0;
            q <= 1'b0;
        end else if (drive_en) begin
            p <= idx[1];
            q <= idx[0];
        end
    end

    // Operator latch and vector index, walking 3 down to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_AND;
            idx  <= 2'd3;
        end else if (accept_ok || accept_bad) begin
            if (accept_ok) begin
                op_q <= op;
            end
            idx <= 2'd3;
        end else if (sample_en && (idx != 2'd0)) begin
            idx <= idx - 2'd1;
        end
    end

    // Settle counter: loaded on every DRIVE, counted down in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (drive_en) begin
            wait_cnt <= SETTLE_CNT;
        end else if (wait_en) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Sweep results: cleared on accept, accumulated per sample, pass resolved on the last vector
    // so everything is already final while done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            bad_op    <= 1'b0;
        end else if (accept_ok || accept_bad) begin
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            bad_op    <= accept_bad;
        end else if (sample_en) begin
            if (mismatch) begin
                err_count     <= err_nxt;
                fail_vec[idx] <= 1'b1;
            end
            if (idx == 2'd0) begin
                pass <= (err_nxt == 3'd0) && !bad_op;
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three instances (SETTLE 0, 1, 3) driven in lockstep,
// each fed by a gate modelled as a 4-entry truth table indexed by {p,q}.
// Expectations come from operator truth tables and the sweep timing formula.
module tb_gate_truth_checker;

    localparam int         N       = 3;
    localparam logic [11:0] ST_PACK = {4'd3, 4'd1, 4'd0};

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [3:0]       gate_tt;

    logic [N-1:0]     result_w;
    logic [N-1:0]     p_w;
    logic [N-1:0]     q_w;
    logic [N-1:0]     busy_w;
    logic [N-1:0]     done_w;
    logic [N-1:0]     pass_w;
    logic [N-1:0]     bad_w;
    logic [2:0]       err_w  [N];
    logic [3:0]       fail_w [N];

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] last_pq = 2'b00;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign result_w[g] = gate_tt[{p_w[g], q_w[g]}];

        gate_truth_checker #(.SETTLE(int'(ST_PACK[g*4 +: 4]))) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .op        (op),
            .result    (result_w[g]),
            .p         (p_w[g]),
            .q         (q_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .pass      (pass_w[g]),
            .err_count (err_w[g]),
            .fail_vec  (fail_w[g]),
            .bad_op    (bad_w[g])
        );
    end

    function automatic int settle_of(input int i);
        return int'(ST_PACK[i*4 +: 4]);
    endfunction

    // Truth table of each operator, bit i = output for {p,q} = i.
    function automatic logic [3:0] op_tt(input logic [2:0] o);
        case (o)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_pq_s%0d", tag, settle_of(i)), {p_w[i], q_w[i]}, 0);
            check($sformatf("%s_busy_s%0d", tag, settle_of(i)), busy_w[i], 0);
            check($sformatf("%s_done_s%0d", tag, settle_of(i)), done_w[i], 0);
            check($sformatf("%s_pass_s%0d", tag, settle_of(i)), pass_w[i], 0);
            check($sformatf("%s_err_s%0d", tag, settle_of(i)), err_w[i], 0);
            check($sformatf("%s_fvec_s%0d", tag, settle_of(i)), fail_w[i], 0);
            check($sformatf("%s_bad_s%0d", tag, settle_of(i)), bad_w[i], 0);
        end
    endtask

    // One sweep on all instances; poke pulses start (with a random op) mid-sweep.
    task automatic run_sweep(input logic [2:0] o, input logic [3:0] gtt, input bit poke);
        bit         valid;
        logic [3:0] exp_fail;
        int         exp_err;
        bit         exp_pass;
        int         c_last;
        int         s;
        int         lat;
        int         k;
        logic [1:0] exp_pq;
        valid    = (o < 3'd6);
        exp_fail = valid ? (op_tt(o) ^ gtt) : 4'b0000;
        exp_err  = $countones(exp_fail);
        exp_pass = valid && (exp_fail == 4'b0000);
        c_last   = valid ? 4 * (3 + 2) + 1 : 1;
        @(negedge clk);
        op      = o;
        gate_tt = gtt;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        for (int c = 0; c <= c_last; c++) begin
            if (poke && c == 3) begin
                start = 1'b1;
                op    = 3'($urandom);
            end
            if (poke && c == 4) start = 1'b0;
            for (int i = 0; i < N; i++) begin
                s   = settle_of(i);
                lat = valid ? 4 * (s + 2) : 0;
                if (c <= lat + 1) begin
                    check($sformatf("busy_s%0d_c%0d", s, c), busy_w[i], (c <= lat));
                    check($sformatf("done_s%0d_c%0d", s, c), done_w[i], (c == lat));
                    if (!valid || c == 0) begin
                        exp_pq = last_pq;
                    end else begin
                        k = (c - 1) / (s + 2);
                        if (k > 3) k = 3;
                        exp_pq = 2'(3 - k);
                    end
                    check($sformatf("pq_s%0d_c%0d", s, c), {p_w[i], q_w[i]}, exp_pq);
                    if (valid && c == 0) begin
                        check($sformatf("pass_clr_s%0d", s), pass_w[i], 0);
                        check($sformatf("err_clr_s%0d", s), err_w[i], 0);
                        check($sformatf("fvec_clr_s%0d", s), fail_w[i], 0);
                        check($sformatf("bad_clr_s%0d", s), bad_w[i], 0);
                    end
                    if (c == lat) begin
                        check($sformatf("err_s%0d_op%0d", s, o), err_w[i], exp_err);
                        check($sformatf("fvec_s%0d_op%0d", s, o), fail_w[i], exp_fail);
                        check($sformatf("pass_s%0d_op%0d", s, o), pass_w[i], exp_pass);
                        check($sformatf("bad_s%0d_op%0d", s, o), bad_w[i], !valid);
                    end
                end
            end
            if (c < c_last) @(negedge clk);
        end
        if (valid) last_pq = 2'b00;
    endtask

    // Reset asserted 5 cycles into a sweep must clear everything at once and never pulse done.
    task automatic reset_mid_sweep();
        @(negedge clk);
        op      = OP_AND;
        gate_tt = op_tt(OP_AND);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("pre_rst_busy_s%0d", settle_of(i)), busy_w[i], 1);
        end
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        last_pq = 2'b00;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
                    check($sformatf("post_rst_idle_s%0d_c%0d", settle_of(i), c),
                          {busy_w[i], done_w[i]}, 0);
                end
            end
        end
        check_all_zero("post_rst");
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        gate_tt = 4'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Correct AND gate, AND expected.
        run_sweep(OP_AND, op_tt(OP_AND), 1'b0);
        // AND gate checked as NAND: every vector wrong.
        run_sweep(OP_NAND, op_tt(OP_AND), 1'b1);
        // OR expected, output stuck at 0, then a correct OR clears the old failures.
        run_sweep(OP_OR, 4'b0000, 1'b0);
        run_sweep(OP_OR, op_tt(OP_OR), 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("pass_hold_s%0d", settle_of(i)), pass_w[i], 1);
        end
        // Invalid operator codes.
        run_sweep(3'd6, op_tt(OP_AND), 1'b0);
        run_sweep(3'd7, 4'b1111, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("bad_hold_s%0d", settle_of(i)), bad_w[i], 1);
        end

        reset_mid_sweep();
        run_sweep(OP_AND, op_tt(OP_AND), 1'b0);

        // Random operators against random gate truth tables.
        for (int n = 0; n < 16; n++) begin
            run_sweep(3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
